// File: rtl/pixel_scaler_pkg.sv
// pixel_scaler_pkg: shared state encoding, zoom-mode constants and address-width helpers.
package pixel_scaler_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic MODE_ZOOM_IN  = 1'b0;
    localparam logic MODE_ZOOM_OUT = 1'b1;

    function automatic int rd_aw(input int w, input int h);
        return (w * h > 1) ? $clog2(w * h) : 1;
    endfunction

    function automatic int wr_aw(input int w, input int h, input int max_shift);
        return $clog2((w * h) << (2 * max_shift));
    endfunction

endpackage

// File: rtl/pixel_scaler_if.sv
// pixel_scaler_if: control, source-read and sink-write signals of the scaler.
interface pixel_scaler_if
    import pixel_scaler_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int RD_AW = rd_aw(160, 120),
    parameter int WR_AW = wr_aw(160, 120, 2)
);
    logic             start;
    logic             mode;
    logic [1:0]       shift;
    logic             rd_en;
    logic [RD_AW-1:0] rd_addr;
    logic [PIX_W-1:0] rd_data;
    logic             wr_en;
    logic [WR_AW-1:0] wr_addr;
    logic [PIX_W-1:0] wr_data;
    logic             wr_ready;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        input  start, mode, shift, rd_data, wr_ready,
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, err
    );

    modport slave (
        output start, mode, shift, rd_data, wr_ready,
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, err
    );
endinterface

// File: rtl/pixel_scaler_fifo.sv
// pixel_scaler_fifo: first-word fall-through FIFO with occupancy count; output reads 0 when empty.
module pixel_scaler_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 3,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp, rp;

    assign empty = count == '0;
    assign dout  = empty ? '0 : mem[rp];

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp == PW'(DEPTH - 1) ? '0 : wp + PW'(1);
            if (pop) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/pixel_scaler.sv
// pixel_scaler: nearest-neighbour power-of-two zoom between a fixed-latency source
// memory and a backpressured sink, with credit-limited reads feeding a skid FIFO.
module pixel_scaler
    import pixel_scaler_pkg::*;
#(
    parameter int IN_W      = 160,
    parameter int IN_H      = 120,
    parameter int PIX_W     = 8,
    parameter int MAX_SHIFT = 2,
    parameter int RD_LAT    = 1
) (
    input logic            clk,
    input logic            reset,
    pixel_scaler_if.master bus
);
    localparam int RD_AW = rd_aw(IN_W, IN_H);
    localparam int WR_AW = wr_aw(IN_W, IN_H, MAX_SHIFT);
    localparam int DEPTH = RD_LAT + 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int XW    = $clog2((IN_W << MAX_SHIFT) + 1);
    localparam int YW    = $clog2((IN_H << MAX_SHIFT) + 1);

    state_t            state, state_n;
    logic              m;
    logic [1:0]        s;
    logic [XW-1:0]     ox;
    logic [YW-1:0]     oy;
    logic [RD_LAT-1:0] vpipe;
    logic [CW-1:0]     inflight, count;
    logic [WR_AW-1:0]  wr_addr;
    logic [31:0]       ow, oh, ix, iy;
    logic              idle, ok, accept, issue, col_end, last, push, pop, empty;

    assign idle   = state == IDLE;
    assign ok     = 32'(bus.shift) <= MAX_SHIFT &&
                    !(bus.mode == MODE_ZOOM_OUT && ((IN_W | IN_H) & ((32'd1 << bus.shift) - 32'd1)) != 0);
    assign accept = bus.start && idle && ok;
    assign ow     = m == MODE_ZOOM_IN ? 32'(IN_W) << s : 32'(IN_W) >> s;
    assign oh     = m == MODE_ZOOM_IN ? 32'(IN_H) << s : 32'(IN_H) >> s;
    assign ix     = m == MODE_ZOOM_IN ? 32'(ox) >> s : 32'(ox) << s;
    assign iy     = m == MODE_ZOOM_IN ? 32'(oy) >> s : 32'(oy) << s;
    // Credits cover FIFO occupancy plus every read still in the memory pipe, so returns always fit.
    assign issue   = state == RUN && 32'(count) + 32'(inflight) < 32'(DEPTH);
    assign col_end = 32'(ox) == ow - 32'd1;
    assign last    = col_end && 32'(oy) == oh - 32'd1;
    assign push    = vpipe[RD_LAT-1];
    assign pop     = !empty && bus.wr_ready;

    assign bus.err     = bus.start && idle && !ok;
    assign bus.rd_en   = issue;
    assign bus.rd_addr = RD_AW'(iy * 32'(IN_W) + ix);
    assign bus.wr_en   = !empty;
    assign bus.wr_addr = wr_addr;
    assign bus.busy    = !idle;
    assign bus.done    = state == DONE;

    pixel_scaler_fifo #(.W(PIX_W), .DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (bus.rd_data),
        .pop   (pop),
        .dout  (bus.wr_data),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end

    // Leaving DRAIN as the final pixel pops makes done land one cycle after the last write.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = RUN;
            RUN:     if (issue && last) state_n = DRAIN;
            DRAIN:   if (inflight == '0 && (empty || (count == CW'(1) && pop))) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m        <= MODE_ZOOM_IN;
            s        <= '0;
            ox       <= '0;
            oy       <= '0;
            vpipe    <= '0;
            inflight <= '0;
            wr_addr  <= '0;
        end else begin
            vpipe    <= RD_LAT'({vpipe, issue});
            inflight <= inflight + CW'(issue) - CW'(push);
            if (accept) begin
                m       <= bus.mode;
                s       <= bus.shift;
                ox      <= '0;
                oy      <= '0;
                wr_addr <= '0;
            end else begin
                if (issue) begin
                    ox <= col_end ? '0 : ox + XW'(1);
                    if (col_end) oy <= oy + YW'(1);
                end
                if (pop) wr_addr <= wr_addr + WR_AW'(1);
            end
        end
    end
endmodule

// File: doc/pixel_scaler.md
# pixel_scaler

Parametrised nearest-neighbour image scaler for the video datapath. It sits between the input frame buffer (read side) and the output frame buffer (write side). It replaces fixed 2x/4x pixel replication with power-of-two zoom-in (replication) and zoom-out (decimation) at any configured frame size. Reads tolerate a fixed memory read latency, and writes honour backpressure through an internal skid FIFO.

## Interface
- IN_W, 160, source frame width in pixels
- IN_H, 120, source frame height in pixels
- PIX_W, 8, pixel width in bits
- MAX_SHIFT, 2, largest log2 scale factor accepted
- RD_LAT, 1, source memory read latency in cycles (>=1)
- clk  in  1  sole clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle request to scale one frame
- mode  in  1  0 = zoom-in (replicate), 1 = zoom-out (decimate); sampled on accepted start
- shift  in  2  log2 scale factor; sampled on accepted start
- rd_en  out  1  source read strobe
- rd_addr  out  clog2(IN_W*IN_H)  source address = iy*IN_W + ix
- rd_data  in  PIX_W  source pixel, valid exactly RD_LAT cycles after rd_en
- wr_en  out  1  output pixel valid
- wr_addr  out  clog2(IN_W*IN_H*4^MAX_SHIFT)  linear output address, row-major from 0
- wr_data  out  PIX_W  output pixel
- wr_ready  in  1  sink accepts a pixel when wr_en && wr_ready
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last output pixel accepted
- err  out  1  one-cycle pulse on rejected start

## Operation
- FSM states:
  - IDLE: busy=0.
  - RUN: issuing reads.
  - DRAIN: all reads issued; waiting for FIFO empty and no reads in flight.
  - DONE: one cycle; done=1; returns to IDLE.
- start in IDLE is accepted unless shift > MAX_SHIFT, or mode=1 and IN_W or IN_H is not divisible by 2^shift.
- Rejected start: err=1 for one cycle; FSM stays in IDLE.
- start while busy: ignored, no err.
- Output size: zoom-in OW=IN_W<<s, OH=IN_H<<s; zoom-out OW=IN_W>>s, OH=IN_H>>s. shift=0 is a straight copy.
- Coordinates: counters ox, oy are row-major; ox wraps at OW-1 and increments oy.
  - Zoom-in: ix=ox>>s, iy=oy>>s.
  - Zoom-out: ix=ox<<s, iy=oy<<s (top-left sample of each block).
- Credit rule: a read issues in RUN only when fifo_count + inflight < RD_LAT+2.
  - inflight counts reads issued but not yet returned.
  - A returning rd_data is pushed to the FIFO in its return cycle.
- FIFO: depth RD_LAT+2, first-word fall-through.
  - wr_en = !empty.
  - Pop on wr_en && wr_ready.
  - wr_addr increments on each pop.
- Last read (ox=OW-1, oy=OH-1) moves RUN to DRAIN. DRAIN moves to DONE once the FIFO is empty and inflight=0.

## Timing
- Reset values: rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0. Counters, inflight and FIFO are cleared; FSM is in IDLE.
- Start accepted in cycle 0:
  - busy=1 from cycle 1.
  - First rd_en in cycle 1.
  - First wr_en in cycle RD_LAT+2.
- With wr_ready held high: one pixel per cycle. With N=OW*OH, rd_en is high in cycles 1..N, wr_en in cycles RD_LAT+2..N+RD_LAT+1, and done fires in cycle N+RD_LAT+2.
- wr_ready low: wr_en, wr_addr and wr_data hold. Reads continue until the credit limit is reached; rd_data is never dropped.
- Reset mid-frame: immediate return to IDLE with the reset values above. Read returns still pending are discarded.
- err and done never coincide with an accepted start.

## Structure
- Shared package pixel_scaler_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - MODE_ZOOM_IN / MODE_ZOOM_OUT constants
  - address-width helper functions
- One sub-module, pixel_scaler_fifo: parametrised FWFT FIFO (width PIX_W, depth RD_LAT+2) with count output.

## Test plan
- Copy, IN_W=4, IN_H=2, RD_LAT=1, mode=0, shift=0, source = address value -> 8 writes, addresses 0..7, data 0..7; done in cycle 11.
- Zoom-in, IN_W=4, IN_H=2, shift=1 -> 32 writes. Row 0 data 0,0,1,1,2,2,3,3; row 3 data 4,4,5,5,6,6,7,7.
- Zoom-out, IN_W=4, IN_H=4, shift=1 -> 4 writes, data 0,2,8,10.
- Backpressure at RD_LAT=3: toggle wr_ready randomly -> the full sequence arrives in order with no loss or duplication. fifo_count + inflight never exceeds 5.
- shift=3 with MAX_SHIFT=2, then zoom-out shift=2 with IN_W=6 -> err pulses, busy stays 0, no rd_en.
- Reset asserted mid-RUN of a default 640x480 zoom-in -> all outputs return to 0 immediately. A following start runs cleanly from wr_addr 0 to done.
